// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core's hazard/pipeline control.
// Contents:
//   DEF_REG_ADDR_W / DEF_COUNT_W - default register-address and counter widths
//   fwd_sel_e                    - E-operand forwarding select encodings
//   stage_flags_t                - per-stage shadow flags (valid, reg_we, is_load)
//   writer_live()                - whether a stage holds a register writer that matters
package riscv_pkg;

   localparam int DEF_REG_ADDR_W = 5;
   localparam int DEF_COUNT_W    = 16;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,   // operand from register file
      FWD_W  = 2'b01,   // operand from W-stage result
      FWD_M  = 2'b10    // operand from M-stage ALU result
   } fwd_sel_e;

   typedef struct packed {
      logic valid;
      logic reg_we;
      logic is_load;
   } stage_flags_t;

   // x0 is hardwired to zero, so a write to it can never feed a reader.
   function automatic logic writer_live(input stage_flags_t flags, input logic rd_nonzero);
      return flags.valid & flags.reg_we & rd_nonzero;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bus between the core datapath and the hazard controller.
// Decode-side signals (dec_*, ex_branch_taken) flow core -> controller;
// stall/flush/pc_src/forward selects, stage valids and counters flow back.
// Modports:
//   master - core datapath side (drives decode info, consumes controls)
//   slave  - hazard controller side
// REG_ADDR_W and COUNT_W must match the controller instance's parameters.
interface pipeline_hazard_ctrl_if
   import riscv_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int COUNT_W    = DEF_COUNT_W
) ();

   logic                  dec_valid;
   logic [REG_ADDR_W-1:0] dec_rs1;
   logic [REG_ADDR_W-1:0] dec_rs2;
   logic                  dec_use_rs1;
   logic                  dec_use_rs2;
   logic [REG_ADDR_W-1:0] dec_rd;
   logic                  dec_reg_we;
   logic                  dec_is_load;
   logic                  ex_branch_taken;

   logic                  stall_F;
   logic                  stall_D;
   logic                  flush_D;
   logic                  flush_E;
   logic                  pc_src;
   logic [1:0]            fwd_a_sel;
   logic [1:0]            fwd_b_sel;
   logic                  valid_E;
   logic                  valid_M;
   logic                  valid_W;
   logic [COUNT_W-1:0]    stall_count;
   logic [COUNT_W-1:0]    flush_count;

   modport master (
      output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
             dec_rd, dec_reg_we, dec_is_load, ex_branch_taken,
      input  stall_F, stall_D, flush_D, flush_E, pc_src,
             fwd_a_sel, fwd_b_sel, valid_E, valid_M, valid_W,
             stall_count, flush_count
   );

   modport slave (
      input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
             dec_rd, dec_reg_we, dec_is_load, ex_branch_taken,
      output stall_F, stall_D, flush_D, flush_E, pc_src,
             fwd_a_sel, fwd_b_sel, valid_E, valid_M, valid_W,
             stall_count, flush_count
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: counts clock cycles with inc=1, sticks at all-ones.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-low reset (clears count)
//   inc   - count this cycle
//   count - current value
module sat_counter #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   output logic [COUNT_W-1:0] count
);

   logic [COUNT_W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= '0;
      end else if (inc && (count_reg != '1)) begin
         count_reg <= count_reg + COUNT_W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and pipeline control for the F/D/E/M/W core.
// Shadows each in-flight instruction's destination/class through E, M, W and
// derives stalls, flushes, E-operand forwarding selects and the branch PC select,
// plus saturating stall/flush performance counters.
// Ports:
//   clk - core clock, rising edge
//   rst - asynchronous active-low reset
//   bus - pipeline_hazard_ctrl_if.slave (decode info in, controls/valids/counters out)
// Parameters:
//   REG_ADDR_W - register address width
//   FWD_EN     - 1: forward from M/W, stall only on load-use; 0: interlock until writer leaves W
//   COUNT_W    - performance counter width
module pipeline_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter bit FWD_EN     = 1'b1,
   parameter int COUNT_W    = DEF_COUNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_hazard_ctrl_if.slave bus
);

   typedef struct packed {
      stage_flags_t          flags;
      logic [REG_ADDR_W-1:0] rd;
   } stage_t;

   localparam int ST_E = 0;
   localparam int ST_M = 1;
   localparam int ST_W = 2;

   stage_t                shd_reg  [3];
   logic [REG_ADDR_W-1:0] e_rs_reg [2];
   logic [1:0]            e_use_reg;

   logic [REG_ADDR_W-1:0] dec_rs [2];
   logic [1:0]            dec_use;
   logic [2:0]            live;
   logic [2:0]            match;
   logic                  hazard;
   logic                  branch;
   logic                  stall;
   logic                  flush_e;
   fwd_sel_e              fwd_sel [2];
   logic [COUNT_W-1:0]    stall_cnt;
   logic [COUNT_W-1:0]    flush_cnt;

   assign dec_rs[0] = bus.dec_rs1;
   assign dec_rs[1] = bus.dec_rs2;
   assign dec_use   = {bus.dec_use_rs2, bus.dec_use_rs1};

   // Per shadow stage: does it hold a live writer, and does D read that register?
   // An invalid D slot never matches.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_stage
         assign live[gi]  = writer_live(shd_reg[gi].flags, shd_reg[gi].rd != '0);
         assign match[gi] = bus.dec_valid & live[gi] &
                            ((dec_use[0] & (dec_rs[0] == shd_reg[gi].rd)) |
                             (dec_use[1] & (dec_rs[1] == shd_reg[gi].rd)));
      end
   endgenerate

   // With forwarding only a load still in E cannot supply its result in time;
   // without it any pending writer blocks D until it has left W.
   assign hazard  = FWD_EN ? (match[ST_E] & shd_reg[ST_E].flags.is_load) : (|match);

   // A taken branch squashes D and E, so any stall for the squashed D is moot.
   assign branch  = bus.ex_branch_taken & shd_reg[ST_E].flags.valid;
   assign stall   = hazard & ~branch;
   assign flush_e = hazard | branch;

   // Forward selects for the instruction now in E. M is younger than W, so it
   // wins; a load in M has no result yet (that case was stalled one cycle earlier).
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         logic m_hit;
         logic w_hit;
         assign m_hit = live[ST_M] & ~shd_reg[ST_M].flags.is_load &
                        (shd_reg[ST_M].rd == e_rs_reg[gi]);
         assign w_hit = live[ST_W] & (shd_reg[ST_W].rd == e_rs_reg[gi]);
         assign fwd_sel[gi] = (!FWD_EN || !shd_reg[ST_E].flags.valid || !e_use_reg[gi]) ? FWD_RF :
                              m_hit ? FWD_M :
                              w_hit ? FWD_W : FWD_RF;
      end
   endgenerate

   // Shadow pipeline: W<-M, M<-E, E<-D or a bubble when E is flushed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            shd_reg[i] <= '0;
         end
         e_rs_reg[0] <= '0;
         e_rs_reg[1] <= '0;
         e_use_reg   <= '0;
      end else begin
         shd_reg[ST_W] <= shd_reg[ST_M];
         shd_reg[ST_M] <= shd_reg[ST_E];
         if (flush_e) begin
            shd_reg[ST_E] <= '0;
            e_rs_reg[0]   <= '0;
            e_rs_reg[1]   <= '0;
            e_use_reg     <= '0;
         end else begin
            shd_reg[ST_E] <= '{flags: '{valid:   bus.dec_valid,
                                        reg_we:  bus.dec_reg_we,
                                        is_load: bus.dec_is_load},
                               rd:    bus.dec_rd};
            e_rs_reg[0]   <= bus.dec_rs1;
            e_rs_reg[1]   <= bus.dec_rs2;
            e_use_reg     <= dec_use;
         end
      end
   end

   sat_counter #(.COUNT_W(COUNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall),
      .count (stall_cnt)
   );

   sat_counter #(.COUNT_W(COUNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (branch),
      .count (flush_cnt)
   );

   assign bus.stall_F     = stall;
   assign bus.stall_D     = stall;
   assign bus.flush_D     = branch;
   assign bus.flush_E     = flush_e;
   assign bus.pc_src      = branch;
   assign bus.fwd_a_sel   = fwd_sel[0];
   assign bus.fwd_b_sel   = fwd_sel[1];
   assign bus.valid_E     = shd_reg[ST_E].flags.valid;
   assign bus.valid_M     = shd_reg[ST_M].flags.valid;
   assign bus.valid_W     = shd_reg[ST_W].flags.valid;
   assign bus.stall_count = stall_cnt;
   assign bus.flush_count = flush_cnt;

endmodule
